// File: rtl/uart_int_ctrl.sv
// UART interrupt scheduler: sticky LSR/MSR status, THRE and char-timeout pending state,
// fixed-priority arbitration into the registered IIR fields and the CPU interrupt line.
module uart_int_ctrl #(
   parameter int CTO_WIDTH = 12
) (
   input  logic                 apb_clk_in,
   input  logic                 apb_rstn_in,
   input  logic                 erbi_in,
   input  logic                 etbei_in,
   input  logic                 elsi_in,
   input  logic                 edssi_in,
   input  logic                 fifoen_in,
   input  logic                 rx_trig_in,
   input  logic                 rx_empty_in,
   input  logic                 rx_push_in,
   input  logic                 rx_pop_in,
   input  logic                 thr_empty_in,
   input  logic                 thr_write_in,
   input  logic                 iir_read_in,
   input  logic                 lsr_read_in,
   input  logic                 msr_read_in,
   input  logic [3:0]           err_in,
   input  logic [3:0]           mdelta_in,
   input  logic                 baud_tick_in,
   input  logic [CTO_WIDTH-1:0] cto_limit_in,
   output logic [2:0]           intid_out,
   output logic                 ipend_out,
   output logic                 fifoed_out,
   output logic                 irq_out,
   output logic [3:0]           lsr_err_out,
   output logic [3:0]           msr_delta_out
);

   localparam logic [2:0] INTID_RLS  = 3'b011;
   localparam logic [2:0] INTID_RDA  = 3'b010;
   localparam logic [2:0] INTID_CTI  = 3'b110;
   localparam logic [2:0] INTID_THRE = 3'b001;
   localparam logic [2:0] INTID_MSI  = 3'b000;

   logic                 thr_empty_q;
   logic                 etbei_q;
   logic                 thre_pend;
   logic                 thre_set;
   logic                 thre_clr;
   logic [CTO_WIDTH-1:0] cto_cnt;
   logic                 cto_pend;
   logic                 cto_clr;
   logic                 cto_en;
   logic                 cto_hit;
   logic [2:0]           intid_nxt;
   logic                 ipend_nxt;

   // THRE re-arms on an empty edge or on enabling while already empty, never on the level.
   assign thre_set = (thr_empty_in & ~thr_empty_q) | (etbei_in & ~etbei_q & thr_empty_in);
   assign thre_clr = thr_write_in |
                     (iir_read_in & ~ipend_out & (intid_out == INTID_THRE));

   assign cto_clr = rx_push_in | rx_pop_in | rx_empty_in | ~fifoen_in | ~erbi_in;
   assign cto_en  = (cto_limit_in != '0);
   assign cto_hit = cto_en && (cto_cnt == cto_limit_in);

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         thr_empty_q   <= 1'b0;
         etbei_q       <= 1'b0;
         thre_pend     <= 1'b0;
         lsr_err_out   <= 4'b0000;
         msr_delta_out <= 4'b0000;
      end else begin
         thr_empty_q   <= thr_empty_in;
         etbei_q       <= etbei_in;
         thre_pend     <= thre_set | (thre_pend & ~thre_clr);
         lsr_err_out   <= err_in | (lsr_err_out & {4{~lsr_read_in}});
         msr_delta_out <= mdelta_in | (msr_delta_out & {4{~msr_read_in}});
      end
   end

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         cto_cnt  <= '0;
         cto_pend <= 1'b0;
      end else if (cto_clr) begin
         cto_cnt  <= '0;
         cto_pend <= 1'b0;
      end else begin
         if (baud_tick_in && (cto_cnt < cto_limit_in)) begin
            cto_cnt <= cto_cnt + 1'b1;
         end
         cto_pend <= cto_pend | cto_hit;
      end
   end

   always_comb begin
      intid_nxt = INTID_MSI;
      ipend_nxt = 1'b1;
      if (elsi_in && (|lsr_err_out)) begin
         intid_nxt = INTID_RLS;
         ipend_nxt = 1'b0;
      end else if (erbi_in && rx_trig_in) begin
         intid_nxt = INTID_RDA;
         ipend_nxt = 1'b0;
      end else if (erbi_in && cto_pend && cto_en) begin
         intid_nxt = INTID_CTI;
         ipend_nxt = 1'b0;
      end else if (etbei_in && thre_pend) begin
         intid_nxt = INTID_THRE;
         ipend_nxt = 1'b0;
      end else if (edssi_in && (|msr_delta_out)) begin
         intid_nxt = INTID_MSI;
         ipend_nxt = 1'b0;
      end
   end

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         intid_out  <= INTID_MSI;
         ipend_out  <= 1'b1;
         irq_out    <= 1'b0;
         fifoed_out <= 1'b0;
      end else begin
         intid_out  <= intid_nxt;
         ipend_out  <= ipend_nxt;
         irq_out    <= ~ipend_nxt;
         fifoed_out <= fifoen_in;
      end
   end

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Directed bench for uart_int_ctrl: stimulus queues expected IIR/status changes,
// a negedge monitor pops and compares each time the DUT outputs change.
module tb_uart_int_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        erbi, etbei, elsi, edssi, fifoen;
   logic        rx_trig, rx_empty, rx_push, rx_pop;
   logic        thr_empty, thr_write, iir_read, lsr_read, msr_read;
   logic [3:0]  err, mdelta;
   logic        baud_tick;
   logic [11:0] cto_limit;
   logic [2:0]  intid;
   logic        ipend, fifoed, irq;
   logic [3:0]  lsr_err, msr_delta;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // iir entry = {fifoed, irq, ipend, intid}; status entry = {lsr_err, msr_delta}
   logic [5:0] iir_q[$];
   logic [7:0] st_q[$];

   always #5 clk = ~clk;

   uart_int_ctrl #(.CTO_WIDTH(12)) dut (
      .apb_clk_in    (clk),
      .apb_rstn_in   (rstn),
      .erbi_in       (erbi),
      .etbei_in      (etbei),
      .elsi_in       (elsi),
      .edssi_in      (edssi),
      .fifoen_in     (fifoen),
      .rx_trig_in    (rx_trig),
      .rx_empty_in   (rx_empty),
      .rx_push_in    (rx_push),
      .rx_pop_in     (rx_pop),
      .thr_empty_in  (thr_empty),
      .thr_write_in  (thr_write),
      .iir_read_in   (iir_read),
      .lsr_read_in   (lsr_read),
      .msr_read_in   (msr_read),
      .err_in        (err),
      .mdelta_in     (mdelta),
      .baud_tick_in  (baud_tick),
      .cto_limit_in  (cto_limit),
      .intid_out     (intid),
      .ipend_out     (ipend),
      .fifoed_out    (fifoed),
      .irq_out       (irq),
      .lsr_err_out   (lsr_err),
      .msr_delta_out (msr_delta)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_iir(input logic [5:0] v);
      iir_q.push_back(v);
   endtask

   task automatic exp_st(input logic [7:0] v);
      st_q.push_back(v);
   endtask

   // Every queued change must have been observed by now.
   task automatic drain(input string name);
      check(name, 8'(iir_q.size() + st_q.size()), 8'd0);
   endtask

   task automatic cto_ticks(input int n, input logic [5:0] fire_val, input bit fire);
      for (int i = 1; i <= n; i++) begin
         if (fire && i == n) exp_iir(fire_val);
         baud_tick = 1'b1;
         step(1);
         baud_tick = 1'b0;
         step(4);
      end
   endtask

   // Monitor: any change of the IIR tuple or the sticky status consumes one expectation.
   initial begin : monitor
      logic [5:0] prev_iir, cur_iir, e_iir;
      logic [7:0] prev_st, cur_st, e_st;
      wait (mon_en);
      prev_iir = {fifoed, irq, ipend, intid};
      prev_st  = {lsr_err, msr_delta};
      forever begin
         @(negedge clk);
         cur_iir = {fifoed, irq, ipend, intid};
         cur_st  = {lsr_err, msr_delta};
         if (cur_iir !== prev_iir) begin
            if (iir_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL iir_unexpected: got %h expected no change from %h at %0t",
                        cur_iir, prev_iir, $time);
            end else begin
               e_iir = iir_q.pop_front();
               check("iir_event", {2'b00, cur_iir}, {2'b00, e_iir});
            end
         end
         if (cur_st !== prev_st) begin
            if (st_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL status_unexpected: got %h expected no change from %h at %0t",
                        cur_st, prev_st, $time);
            end else begin
               e_st = st_q.pop_front();
               check("status_event", cur_st, e_st);
            end
         end
         prev_iir = cur_iir;
         prev_st  = cur_st;
      end
   end

   initial begin
      rstn = 1'b0;
      {erbi, etbei, elsi, edssi, fifoen} = '0;
      {rx_trig, rx_push, rx_pop, thr_empty, thr_write} = '0;
      {iir_read, lsr_read, msr_read, baud_tick} = '0;
      rx_empty  = 1'b1;
      err       = 4'b0000;
      mdelta    = 4'b0000;
      cto_limit = 12'd0;
      step(3);
      check("reset_iir", {2'b00, fifoed, irq, ipend, intid}, 8'b00_0_0_1_000);
      check("reset_status", {lsr_err, msr_delta}, 8'h00);
      rstn = 1'b1;
      step(2);
      mon_en = 1'b1;
      step(2);

      // THRE fire, IIR-read acknowledge, no re-fire on the steady level
      etbei = 1'b1;
      step(2);
      thr_empty = 1'b1;
      exp_iir(6'b0_1_0_001);
      step(4);
      drain("t2_thre_fire");
      iir_read = 1'b1;
      exp_iir(6'b0_0_1_000);
      step(1);
      iir_read = 1'b0;
      step(6);
      drain("t2_ack_no_refire");

      // Async reset while THRE is pending
      thr_empty = 1'b0;
      step(2);
      thr_empty = 1'b1;
      exp_iir(6'b0_1_0_001);
      step(4);
      drain("t1_thre_pending");
      exp_iir(6'b0_0_1_000);
      rstn = 1'b0;
      #1;
      check("t1_async_reset", {3'b000, irq, ipend, intid}, 8'b000_0_1_000);
      thr_empty = 1'b0;
      etbei     = 1'b0;
      step(2);
      rstn = 1'b1;
      step(4);
      drain("t1_reset_clean");

      // THRE latched while disabled, shown when etbei rises; thr_write clears
      thr_empty = 1'b1;
      step(2);
      etbei = 1'b1;
      exp_iir(6'b0_1_0_001);
      step(4);
      drain("etbei_rise");
      thr_write = 1'b1;
      exp_iir(6'b0_0_1_000);
      step(1);
      thr_write = 1'b0;
      etbei = 1'b0;
      step(4);
      drain("thr_write_clear");

      // Line status beats RX data; LSR read drops to RX data
      elsi = 1'b1;
      erbi = 1'b1;
      step(1);
      err = 4'b0001;
      exp_st(8'b0001_0000);
      exp_iir(6'b0_1_0_011);
      step(1);
      err = 4'b0000;
      step(4);
      drain("t3_rls");
      rx_trig = 1'b1;
      step(4);
      drain("t3_rda_masked");
      lsr_read = 1'b1;
      exp_st(8'h00);
      exp_iir(6'b0_1_0_010);
      step(1);
      lsr_read = 1'b0;
      step(4);
      drain("t3_rda_after_read");

      // New error in the same cycle as LSR read survives the read
      err = 4'b0001;
      exp_st(8'b0001_0000);
      exp_iir(6'b0_1_0_011);
      step(1);
      err = 4'b0000;
      step(4);
      drain("t5_rls_again");
      lsr_read = 1'b1;
      err      = 4'b0100;
      exp_st(8'b0100_0000);
      step(1);
      lsr_read = 1'b0;
      err      = 4'b0000;
      step(4);
      drain("t5_collision");
      lsr_read = 1'b1;
      exp_st(8'h00);
      exp_iir(6'b0_1_0_010);
      step(1);
      lsr_read = 1'b0;
      step(4);
      drain("t5_cleared");
      rx_trig = 1'b0;
      exp_iir(6'b0_0_1_000);
      step(4);
      drain("rda_idle");
      elsi = 1'b0;

      // Character timeout at exactly cto_limit ticks
      fifoen = 1'b1;
      exp_iir(6'b1_0_1_000);
      step(3);
      drain("fifoed_set");
      cto_limit = 12'd40;
      rx_empty  = 1'b0;
      rx_push   = 1'b1;
      step(1);
      rx_push = 1'b0;
      cto_ticks(40, 6'b1_1_0_110, 1'b1);
      drain("t4_cto_fire");
      rx_pop = 1'b1;
      exp_iir(6'b1_0_1_000);
      step(1);
      rx_pop = 1'b0;
      step(4);
      drain("t4_pop_clear");
      cto_ticks(40, 6'b1_1_0_110, 1'b1);
      drain("t4_recount_from_zero");
      rx_empty = 1'b1;
      exp_iir(6'b1_0_1_000);
      step(4);
      drain("t4_empty_clear");

      // Zero limit disables the timeout
      cto_limit = 12'd0;
      rx_empty  = 1'b0;
      rx_push   = 1'b1;
      step(1);
      rx_push = 1'b0;
      cto_ticks(50, 6'b0, 1'b0);
      drain("cto_limit_zero");

      // erbi=0 clears the pending timeout
      cto_limit = 12'd3;
      cto_ticks(3, 6'b1_1_0_110, 1'b1);
      drain("cto_small_limit");
      erbi = 1'b0;
      exp_iir(6'b1_0_1_000);
      step(4);
      drain("cto_erbi_clear");
      rx_empty  = 1'b1;
      fifoen    = 1'b0;
      cto_limit = 12'd0;
      exp_iir(6'b0_0_1_000);
      step(4);
      drain("fifoed_clear");

      // Modem status and MSR read
      edssi  = 1'b1;
      mdelta = 4'b0001;
      exp_st(8'b0000_0001);
      exp_iir(6'b0_1_0_000);
      step(1);
      mdelta = 4'b0000;
      step(4);
      drain("t6_msi");
      msr_read = 1'b1;
      exp_st(8'h00);
      exp_iir(6'b0_0_1_000);
      step(1);
      msr_read = 1'b0;
      step(4);
      drain("t6_msr_read");

      // Delta latched while disabled, shown on enable; read/set collision
      edssi = 1'b0;
      step(1);
      mdelta = 4'b0100;
      exp_st(8'b0000_0100);
      step(1);
      mdelta = 4'b0000;
      step(4);
      drain("msi_masked");
      edssi = 1'b1;
      exp_iir(6'b0_1_0_000);
      step(4);
      drain("msi_enable");
      msr_read = 1'b1;
      mdelta   = 4'b0010;
      exp_st(8'b0000_0010);
      step(1);
      msr_read = 1'b0;
      mdelta   = 4'b0000;
      step(4);
      drain("msr_collision");

      // THRE outranks modem status
      etbei = 1'b1;
      exp_iir(6'b0_1_0_001);
      step(4);
      drain("thre_over_msi");
      thr_write = 1'b1;
      exp_iir(6'b0_1_0_000);
      step(1);
      thr_write = 1'b0;
      step(4);
      drain("msi_after_thre");
      msr_read = 1'b1;
      exp_st(8'h00);
      exp_iir(6'b0_0_1_000);
      step(1);
      msr_read = 1'b0;
      step(4);
      drain("final_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
